// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Widest one-hot vector the index helper accepts.
  localparam int unsigned MAX_N = 64;

  function automatic int unsigned oh_to_idx(input logic [MAX_N-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: lowest request at or above the one-hot pointer, else lowest overall.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] winner_c
);

  logic [N-1:0] ge_mask;
  logic [N-1:0] masked;

  always_comb begin
    ge_mask = ~(ptr - N'(1));
    masked  = req & ge_mask;
    // Isolating the lowest set bit with x & -x.
    if (|masked) winner_c = masked & (~masked + N'(1));
    else         winner_c = req & (~req + N'(1));
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Packet-aware weighted round-robin arbiter: an owner keeps the grant for
// up to eff_weight whole packets, then priority rotates to the next agent.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned WEIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          req_last,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  out_ready,
  output logic [N-1:0]          grant,
  output logic [$clog2(N)-1:0]  grant_idx,
  output logic                  out_valid
);

  localparam int unsigned IDX_W = $clog2(N);

  arb_state_e          state_q, state_d;
  logic [N-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [N-1:0]        ptr_q, ptr_d;
  logic                pkt_open_q, pkt_open_d;

  logic [N-1:0]        winner_c;
  logic [IDX_W-1:0]    win_idx_c;
  logic [WEIGHT_W-1:0] win_w_c;
  logic                xfer_c;
  logic                release_c;

  rr_pick #(.N(N)) u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .winner_c (winner_c)
  );

  assign win_idx_c = IDX_W'(oh_to_idx(MAX_N'(winner_c)));

  // Weight of the candidate winner, sampled only on the IDLE -> OWNED load.
  always_comb begin
    win_w_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (winner_c[i]) win_w_c = weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign out_valid = (|grant_q) & req[grant_idx_q];
  assign xfer_c    = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    credit_d    = credit_q;
    ptr_d       = ptr_q;
    pkt_open_d  = pkt_open_q;
    release_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = OWNED;
          grant_d     = winner_c;
          grant_idx_d = win_idx_c;
          credit_d    = (win_w_c == '0) ? '0 : win_w_c - WEIGHT_W'(1);
          pkt_open_d  = 1'b0;
        end
      end
      OWNED: begin
        if (xfer_c) begin
          if (req_last[grant_idx_q]) begin
            pkt_open_d = 1'b0;
            if (credit_q != '0) credit_d = credit_q - WEIGHT_W'(1);
            else                release_c = 1'b1;
          end else begin
            pkt_open_d = 1'b1;
          end
        end else if (!pkt_open_q && !req[grant_idx_q]) begin
          // Owner went quiet between packets: give up the remaining turn.
          release_c = 1'b1;
        end

        if (release_c) begin
          state_d     = IDLE;
          grant_d     = '0;
          grant_idx_d = '0;
          ptr_d       = {grant_q[N-2:0], grant_q[N-1]};
          pkt_open_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      credit_q    <= '0;
      ptr_q       <= N'(1);
      pkt_open_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      credit_q    <= credit_d;
      ptr_q       <= ptr_d;
      pkt_open_q  <= pkt_open_d;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Table-driven bench for wrr_arbiter with a queue of expected per-cycle outputs.
module tb_wrr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned WW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  req_last;
  logic [N*WW-1:0] weight;
  logic          out_ready;
  logic [N-1:0]  grant;
  logic [1:0]    grant_idx;
  logic          out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .WEIGHT_W(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_last  (req_last),
    .weight    (weight),
    .out_ready (out_ready),
    .grant     (grant),
    .grant_idx (grant_idx),
    .out_valid (out_valid)
  );

  typedef struct {
    int          tid;
    bit          rst;
    logic [3:0]  pre_req;
    logic [3:0]  req;
    logic [3:0]  last;
    logic        rdy;
    logic [15:0] w;
    logic [3:0]  eg;
    logic        ev;
  } vec_t;

  typedef struct {
    int         tid;
    int         step;
    logic [3:0] g;
    logic [1:0] idx;
    logic       v;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(int tid, bit rst, logic [3:0] pre, logic [3:0] rq,
                              logic [3:0] lst, logic rdy, logic [15:0] w,
                              logic [3:0] eg, logic ev);
    vec_t v;
    v.tid = tid; v.rst = rst; v.pre_req = pre; v.req = rq; v.last = lst;
    v.rdy = rdy; v.w = w; v.eg = eg; v.ev = ev;
    return v;
  endfunction

  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string name, input int tid, input int step,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s test%0d step%0d: got %0h expected %0h", name, tid, step, act, exp);
    end
  endtask

  // Reset with inputs already set for the first arbitration after release.
  task automatic do_reset(input int tid, input logic [3:0] pre, input logic [15:0] w);
    rst_n     = 1'b0;
    req       = pre;
    req_last  = '0;
    out_ready = 1'b0;
    weight    = w;
    #1;
    chk("reset_grant", tid, -1, 32'(grant), 32'h0);
    chk("reset_idx", tid, -1, 32'(grant_idx), 32'h0);
    chk("reset_valid", tid, -1, 32'(out_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ($countones(grant) > 1) begin
        errors++;
        $display("FAIL onehot: grant=%b has more than one bit set", grant);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    exp_t e;
    int   step;

    // Rotation with unit weights, one idle cycle between owners.
    vecs.push_back(mk(1, 1, 4'hF, 4'hF, 4'hF, 1, 16'h1111, 4'b0001, 1));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 4'hF, 1, 16'h1111, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 4'hF, 1, 16'h1111, 4'b0010, 1));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 4'hF, 1, 16'h1111, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 4'hF, 1, 16'h1111, 4'b0100, 1));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 4'hF, 1, 16'h1111, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 4'hF, 1, 16'h1111, 4'b1000, 1));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 4'hF, 1, 16'h1111, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 4'hF, 1, 16'h1111, 4'b0001, 1));
    // Agent 0 weight 3: three back-to-back packets, then agent 1, then agent 0.
    vecs.push_back(mk(2, 1, 4'h3, 4'h3, 4'hF, 1, 16'h1113, 4'b0001, 1));
    vecs.push_back(mk(2, 0, 4'h3, 4'h3, 4'hF, 1, 16'h1113, 4'b0001, 1));
    vecs.push_back(mk(2, 0, 4'h3, 4'h3, 4'hF, 1, 16'h1113, 4'b0001, 1));
    vecs.push_back(mk(2, 0, 4'h3, 4'h3, 4'hF, 1, 16'h1113, 4'b0000, 0));
    vecs.push_back(mk(2, 0, 4'h3, 4'h3, 4'hF, 1, 16'h1113, 4'b0010, 1));
    vecs.push_back(mk(2, 0, 4'h3, 4'h3, 4'hF, 1, 16'h1113, 4'b0000, 0));
    vecs.push_back(mk(2, 0, 4'h3, 4'h3, 4'hF, 1, 16'h1113, 4'b0001, 1));
    // Agent 2 four-beat packet under toggling backpressure.
    vecs.push_back(mk(3, 1, 4'h4, 4'hF, 4'h0, 1, 16'h1111, 4'b0100, 1));
    vecs.push_back(mk(3, 0, 4'h4, 4'hF, 4'h0, 0, 16'h1111, 4'b0100, 1));
    vecs.push_back(mk(3, 0, 4'h4, 4'hF, 4'h0, 1, 16'h1111, 4'b0100, 1));
    vecs.push_back(mk(3, 0, 4'h4, 4'hF, 4'h0, 0, 16'h1111, 4'b0100, 1));
    vecs.push_back(mk(3, 0, 4'h4, 4'hF, 4'h0, 1, 16'h1111, 4'b0100, 1));
    vecs.push_back(mk(3, 0, 4'h4, 4'hF, 4'h0, 0, 16'h1111, 4'b0100, 1));
    vecs.push_back(mk(3, 0, 4'h4, 4'hF, 4'h4, 1, 16'h1111, 4'b0100, 1));
    vecs.push_back(mk(3, 0, 4'h4, 4'hF, 4'h0, 0, 16'h1111, 4'b0000, 0));
    vecs.push_back(mk(3, 0, 4'h4, 4'hF, 4'h0, 0, 16'h1111, 4'b1000, 1));
    // Owner drops req mid-packet (held), then between packets (released).
    vecs.push_back(mk(4, 1, 4'h1, 4'h1, 4'h0, 1, 16'h1113, 4'b0001, 1));
    vecs.push_back(mk(4, 0, 4'h1, 4'h0, 4'h0, 1, 16'h1113, 4'b0001, 0));
    vecs.push_back(mk(4, 0, 4'h1, 4'h0, 4'h0, 1, 16'h1113, 4'b0001, 0));
    vecs.push_back(mk(4, 0, 4'h1, 4'h1, 4'h1, 1, 16'h1113, 4'b0001, 1));
    vecs.push_back(mk(4, 0, 4'h1, 4'h0, 4'h0, 1, 16'h1113, 4'b0001, 0));
    vecs.push_back(mk(4, 0, 4'h1, 4'h0, 4'h0, 1, 16'h1113, 4'b0000, 0));
    // Zero weight on agent 1 acts as weight 1.
    vecs.push_back(mk(5, 1, 4'h3, 4'h3, 4'hF, 1, 16'h1101, 4'b0001, 1));
    vecs.push_back(mk(5, 0, 4'h3, 4'h3, 4'hF, 1, 16'h1101, 4'b0000, 0));
    vecs.push_back(mk(5, 0, 4'h3, 4'h3, 4'hF, 1, 16'h1101, 4'b0010, 1));
    vecs.push_back(mk(5, 0, 4'h3, 4'h3, 4'hF, 1, 16'h1101, 4'b0000, 0));
    vecs.push_back(mk(5, 0, 4'h3, 4'h3, 4'hF, 1, 16'h1101, 4'b0001, 1));
    vecs.push_back(mk(5, 0, 4'h3, 4'h3, 4'hF, 1, 16'h1101, 4'b0000, 0));
    vecs.push_back(mk(5, 0, 4'h3, 4'h3, 4'hF, 1, 16'h1101, 4'b0010, 1));
    // Reset while agent 3 owns mid-packet, then re-grant after release.
    vecs.push_back(mk(6, 1, 4'h8, 4'h8, 4'h0, 1, 16'h1111, 4'b1000, 1));
    vecs.push_back(mk(6, 1, 4'h8, 4'h8, 4'h8, 1, 16'h1111, 4'b1000, 1));
    vecs.push_back(mk(6, 0, 4'h8, 4'h8, 4'h0, 0, 16'h1111, 4'b0000, 0));

    step = 0;
    foreach (vecs[k]) begin
      v = vecs[k];
      if (v.rst) begin
        do_reset(v.tid, v.pre_req, v.w);
        step = 0;
      end
      @(posedge clk);
      #1;
      req       = v.req;
      req_last  = v.last;
      out_ready = v.rdy;
      weight    = v.w;
      e.tid  = v.tid;
      e.step = step;
      e.g    = v.eg;
      e.idx  = oh_idx(v.eg);
      e.v    = v.ev;
      exp_q.push_back(e);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: queue empty at vector %0d", k);
      end else begin
        e = exp_q.pop_front();
        chk("grant", e.tid, e.step, 32'(grant), 32'(e.g));
        chk("grant_idx", e.tid, e.step, 32'(grant_idx), 32'(e.idx));
        chk("out_valid", e.tid, e.step, 32'(out_valid), 32'(e.v));
      end
      step++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requestors (N >= 2).
REQ-002 Parameter WEIGHT_W, default 4: width of each per-requestor weight field.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N  per-requestor request; bit i belongs to agent i; held high while agent i has a beat pending.
REQ-006 req_last  input  N  bit i marks agent i's current beat as the last beat of its packet.
REQ-007 weight  input  N*WEIGHT_W  packets-per-turn for each agent; field i is bits [i*WEIGHT_W +: WEIGHT_W]; quasi-static.
REQ-008 out_ready  input  1  downstream accepts a beat this cycle.
REQ-009 grant  output  N  one-hot registered grant, or all-zero.
REQ-010 grant_idx  output  $clog2(N)  binary index of the granted agent; 0 when grant is zero.
REQ-011 out_valid  output  1  equals req[grant_idx] AND (grant != 0).

Function
REQ-012 States: IDLE (no owner) and OWNED (one agent holds grant); state register is a two-state FSM.
REQ-013 IDLE with req != 0: winner = lowest-index set bit of req at or above the priority pointer, else lowest-index set bit of req overall; next cycle is OWNED with grant = onehot(winner), credit = eff_weight(winner) - 1.
REQ-014 IDLE with req == 0: stay IDLE, grant = 0, pointer and credit unchanged.
REQ-015 eff_weight(i) = weight field i, except a field value of 0 is treated as 1.
REQ-016 Grant latency: one clock from req first sampled high in IDLE to grant asserted.
REQ-017 Beat transfer occurs in a cycle where out_valid and out_ready are both high.
REQ-018 OWNED, transfer with req_last[owner] = 0: hold grant, credit unchanged.
REQ-019 OWNED, transfer with req_last[owner] = 1 and credit > 0: decrement credit, keep grant (back-to-back packet, no idle cycle).
REQ-020 OWNED, transfer with req_last[owner] = 1 and credit == 0: release; pointer = onehot(owner+1 mod N), wrap N-1 -> 0; go IDLE; grant = 0 next cycle.
REQ-021 OWNED with req[owner] = 0 at a packet boundary (credit > 0, after a last beat): release exactly as REQ-020 on the cycle req drops.
REQ-022 OWNED mid-packet with req[owner] = 0: hold grant; the packet is never split.
REQ-023 req of other agents is ignored while OWNED; no preemption.
REQ-024 Weight changes take effect only at the next IDLE -> OWNED load.
REQ-025 Credit counter is WEIGHT_W bits wide, unsigned, never underflows.
REQ-026 grant has at most one bit set in every cycle.

Reset
REQ-027 On rst_n low, asynchronously: state = IDLE, grant = 0, grant_idx = 0, out_valid = 0, credit = 0, pointer = onehot(0).
REQ-028 Reset asserted mid-packet discards ownership; the first arbitration after reset release starts from agent 0 priority.

Structure
REQ-029 Shared package arb_pkg holds the state enum (IDLE, OWNED) and an onehot-to-index helper function.
REQ-030 The masked/unmasked two-stage priority pick is a sub-module, rr_pick, parameterised by N, which takes req and pointer and returns a one-hot winner combinationally.
REQ-031 wrr_arbiter contains only the FSM, credit counter, pointer register and output registers.

Verification
REQ-032 Reset, then req=4'b1111, weight all 1, out_ready=1, every beat last: grants 0,1,2,3,0, each granted agent holding for one cycle followed by one IDLE cycle.
REQ-033 weight = {1,1,1,3} (agent 0 = 3), req=4'b0011, single-beat packets: agent 0 is granted for 3 consecutive transfers, then agent 1 for 1, then agent 0 again.
REQ-034 Agent 2 sends a 4-beat packet with out_ready toggled 1,0,1,0..., and req=4'b1111 throughout: grant stays 4'b0100 until the 4th transfer with req_last, then moves to agent 3.
REQ-035 Owner drops req mid-packet for 2 cycles: grant is held, and out_valid = 0 during those 2 cycles.
REQ-036 weight field = 0 for agent 1: behaves as weight 1, and agent 1 is granted exactly once per round.
REQ-037 Assert rst_n low while agent 3 is OWNED: grant is 0 immediately, and after release with req=4'b1000 agent 3 is granted one cycle later.
